dtw_traceback: RTL and testbench

Downstream traceback stage of the DTW array. It captures the 2-bit predecessor code that each score cell resolves during the forward pass. On command, it walks the optimal warping path from the end cell back to the origin (0,0). Each visited cell is emitted as a 10-bit {tindex, rindex} word over a valid/ready stream to the result-SRAM writer, one cell per beat.

---
 rtl/dtw_pkg.sv | 36 +++
 rtl/dtw_path_mem.sv | 46 ++++
 rtl/dtw_traceback.sv | 145 ++++++++++++++
 tb/tb_dtw_traceback.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared DTW definitions: index width, path codes and traceback FSM states.
package dtw_pkg;

   localparam int IDX_W = 5;
   localparam logic [IDX_W-1:0] INVALID_IDX = 5'd31;

   // Predecessor codes written by the score array, one per cell.
   localparam logic [1:0] PATH_DIAG = 2'b11;
   localparam logic [1:0] PATH_UP   = 2'b10;
   localparam logic [1:0] PATH_LEFT = 2'b01;
   localparam logic [1:0] PATH_NONE = 2'b00;

   // Legacy state encodings; the enum below is built on top of them.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   typedef enum logic [0:0] {
      STATE_IDLE = ST_IDLE,
      STATE_EMIT = ST_EMIT
   } dtw_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] t;
      logic [IDX_W-1:0] r;
   } dtw_cell_t;

   // True when both coordinates address a real cell of the matrix.
   // An index equal to INVALID_IDX is never in range because lengths cap at 31.
   function automatic logic cell_in_range(input logic [IDX_W-1:0] t,
                                          input logic [IDX_W-1:0] r,
                                          input logic [IDX_W-1:0] t_lim,
                                          input logic [IDX_W-1:0] r_lim);
      return (t < t_lim) && (r < r_lim) && (t != INVALID_IDX) && (r != INVALID_IDX);
   endfunction

endpackage

// File: rtl/dtw_path_mem.sv
// Predecessor-code register file: async clear, one sync write, one comb read.
module dtw_path_mem
   import dtw_pkg::*;
#(
   parameter int T_LEN = 31,
   parameter int R_LEN = 31
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_t,
   input  logic [IDX_W-1:0] wr_r,
   input  logic [1:0]       wr_data,
   input  logic [IDX_W-1:0] rd_t,
   input  logic [IDX_W-1:0] rd_r,
   output logic [1:0]       rd_data
);

   localparam logic [IDX_W-1:0] T_MAX = IDX_W'(T_LEN);
   localparam logic [IDX_W-1:0] R_MAX = IDX_W'(R_LEN);

   logic [1:0] mem [T_LEN][R_LEN];

   // Clear every cell on reset; otherwise store the write when enabled.
   // The caller qualifies wr_en with range and FSM state.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < T_LEN; i++) begin
            for (int j = 0; j < R_LEN; j++) begin
               mem[i][j] <= PATH_NONE;
            end
         end
      end else if (wr_en) begin
         mem[wr_t][wr_r] <= wr_data;
      end
   end

   // Out-of-range reads return PATH_NONE rather than an undefined word.
   always_comb begin
      rd_data = PATH_NONE;
      if (cell_in_range(rd_t, rd_r, T_MAX, R_MAX)) begin
         rd_data = mem[rd_t][rd_r];
      end
   end

endmodule

// File: rtl/dtw_traceback.sv
// DTW traceback: walks stored predecessor codes from the end cell to (0,0)
// and streams each visited {tindex, rindex} over valid/ready.
//
// state | meaning
// IDLE  | accepting path writes, waiting for i_start
// EMIT  | presenting cur on the stream, stepping on each handshake
module dtw_traceback
   import dtw_pkg::*;
#(
   parameter int T_LEN = 31,
   parameter int R_LEN = 31
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_tindex,
   input  logic [IDX_W-1:0]   i_wr_rindex,
   input  logic [1:0]         i_wr_path,
   input  logic               i_start,
   input  logic [IDX_W-1:0]   i_tend,
   input  logic [IDX_W-1:0]   i_rend,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*IDX_W-1:0] o_index,
   output logic               o_last,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err
);

   localparam logic [IDX_W-1:0] T_MAX = IDX_W'(T_LEN);
   localparam logic [IDX_W-1:0] R_MAX = IDX_W'(R_LEN);

   dtw_state_e state;
   dtw_cell_t  cur;
   dtw_cell_t  nxt_cell;
   logic       step_ok;
   logic [1:0] code;
   logic       mem_we;
   logic       start_ok;
   logic       at_origin;
   logic       done_q;
   logic       err_q;

   // Writes are only taken while idle so the path cannot change under a walk.
   assign mem_we    = i_wr_en && (state == STATE_IDLE) &&
                      cell_in_range(i_wr_tindex, i_wr_rindex, T_MAX, R_MAX);
   assign start_ok  = cell_in_range(i_tend, i_rend, T_MAX, R_MAX);
   assign at_origin = (cur.t == '0) && (cur.r == '0);

   dtw_path_mem #(
      .T_LEN (T_LEN),
      .R_LEN (R_LEN)
   ) u_path_mem (
      .clk     (clk),
      .nrst    (nrst),
      .wr_en   (mem_we),
      .wr_t    (i_wr_tindex),
      .wr_r    (i_wr_rindex),
      .wr_data (i_wr_path),
      .rd_t    (cur.t),
      .rd_r    (cur.r),
      .rd_data (code)
   );

   // Decode the predecessor of cur; a step that would underflow is illegal.
   always_comb begin
      nxt_cell = cur;
      step_ok  = 1'b0;
      case (code)
         PATH_DIAG: begin
            if ((cur.t != '0) && (cur.r != '0)) begin
               nxt_cell.t = cur.t - 5'd1;
               nxt_cell.r = cur.r - 5'd1;
               step_ok    = 1'b1;
            end
         end
         PATH_UP: begin
            if (cur.t != '0) begin
               nxt_cell.t = cur.t - 5'd1;
               step_ok    = 1'b1;
            end
         end
         PATH_LEFT: begin
            if (cur.r != '0) begin
               nxt_cell.r = cur.r - 5'd1;
               step_ok    = 1'b1;
            end
         end
         default: begin
            step_ok = 1'b0;
         end
      endcase
   end

   // FSM, current-cell register and the one-cycle done/err pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state  <= STATE_IDLE;
         cur    <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (i_start) begin
                  if (start_ok) begin
                     cur.t <= i_tend;
                     cur.r <= i_rend;
                     state <= STATE_EMIT;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            STATE_EMIT: begin
               if (i_ready) begin
                  if (at_origin) begin
                     state  <= STATE_IDLE;
                     done_q <= 1'b1;
                  end else if (step_ok) begin
                     cur <= nxt_cell;
                  end else begin
                     state <= STATE_IDLE;
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state <= STATE_IDLE;
            end
         endcase
      end
   end

   assign o_valid = (state == STATE_EMIT);
   assign o_busy  = (state == STATE_EMIT);
   assign o_index = cur;
   assign o_last  = (state == STATE_EMIT) && at_origin;
   assign o_done  = done_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_dtw_traceback.sv
// Bench for dtw_traceback: directed vector table, hand-built corner
// sequences and randomized paths checked against a cell-walking model.
module tb_dtw_traceback;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       i_wr_en = 1'b0;
   logic [4:0] i_wr_tindex = '0;
   logic [4:0] i_wr_rindex = '0;
   logic [1:0] i_wr_path = '0;
   logic       i_start = 1'b0;
   logic [4:0] i_tend = '0;
   logic [4:0] i_rend = '0;
   logic       o_valid;
   logic       i_ready = 1'b0;
   logic [9:0] o_index;
   logic       o_last;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   always #5 clk = ~clk;

   dtw_traceback dut (
      .clk         (clk),
      .nrst        (nrst),
      .i_wr_en     (i_wr_en),
      .i_wr_tindex (i_wr_tindex),
      .i_wr_rindex (i_wr_rindex),
      .i_wr_path   (i_wr_path),
      .i_start     (i_start),
      .i_tend      (i_tend),
      .i_rend      (i_rend),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_index     (o_index),
      .o_last      (o_last),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   int total = 0;
   int bad = 0;

   int         model_mem [31][31];
   logic [9:0] exp_q [$];
   bit         exp_ok;

   typedef struct {
      string            nm;
      int               setup;
      int               te;
      int               re;
      int               rmode;
      int               n;
      logic [3:0][9:0]  beats;
      bit               ok;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
      end
   endtask

   function automatic void model_clear();
      for (int t = 0; t < 31; t++)
         for (int r = 0; r < 31; r++)
            model_mem[t][r] = 0;
   endfunction

   // Expected beat list: follow predecessor codes from the end cell.
   function automatic void build(input int te, input int re);
      int t;
      int r;
      int c;
      exp_q.delete();
      exp_ok = 1'b0;
      if (te >= 31 || re >= 31) return;
      t = te;
      r = re;
      forever begin
         exp_q.push_back(10'(t * 32 + r));
         if (t == 0 && r == 0) begin
            exp_ok = 1'b1;
            return;
         end
         c = model_mem[t][r];
         if (c == 3 && t > 0 && r > 0) begin t--; r--; end
         else if (c == 2 && t > 0) t--;
         else if (c == 1 && r > 0) r--;
         else return;
      end
   endfunction

   task automatic do_reset();
      nrst = 1'b0;
      i_wr_en = 1'b0;
      i_start = 1'b0;
      i_ready = 1'b0;
      @(posedge clk) #1;
      nrst = 1'b1;
      model_clear();
      @(posedge clk) #1;
   endtask

   task automatic wr(input int t, input int r, input int c);
      i_wr_en = 1'b1;
      i_wr_tindex = 5'(t);
      i_wr_rindex = 5'(r);
      i_wr_path = 2'(c);
      @(posedge clk) #1;
      i_wr_en = 1'b0;
      if (t < 31 && r < 31) model_mem[t][r] = c;
   endtask

   task automatic start(input int te, input int re);
      i_start = 1'b1;
      i_tend = 5'(te);
      i_rend = 5'(re);
      @(posedge clk) #1;
      i_start = 1'b0;
   endtask

   task automatic setup(input int s);
      case (s)
         1: for (int t = 0; t < 3; t++)
               for (int r = 0; r < 3; r++)
                  wr(t, r, 3);
         2: begin wr(2, 1, 2); wr(1, 1, 1); wr(1, 0, 2); end
         3: wr(2, 2, 3);
         4: wr(0, 2, 2);
         default: ;
      endcase
   endtask

   function automatic bit ready_pick(input int mode, input int rc);
      if (mode == 1) return (rc % 3) == 0;
      if (mode == 2) return 1'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   // Entered just after the edge that starts the first EMIT cycle (or the
   // cycle following an illegal start); checks every beat against exp_q.
   task automatic watch(input string nm, input int rmode);
      int         beats = 0;
      int         rc = 0;
      int         cyc = 0;
      bit         fin = 1'b0;
      bit         hold = 1'b0;
      logic [9:0] held = '0;
      while (!fin && cyc < 500) begin
         i_ready = ready_pick(rmode, rc);
         rc++;
         @(negedge clk);
         cyc++;
         if (o_valid) begin
            chk({nm, " busy"}, int'(o_busy), 1);
            if (hold) chk({nm, " hold"}, int'(o_index), int'(held));
            if (beats < exp_q.size()) begin
               chk({nm, " index"}, int'(o_index), int'(exp_q[beats]));
               chk({nm, " last"}, int'(o_last), int'(exp_q[beats] == 10'd0));
            end else begin
               chk({nm, " extra beat"}, beats, exp_q.size() - 1);
            end
            if (i_ready) begin
               beats++;
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               held = o_index;
            end
         end else begin
            fin = 1'b1;
            chk({nm, " beats"}, beats, exp_q.size());
            chk({nm, " done"}, int'(o_done), int'(exp_ok));
            chk({nm, " err"}, int'(o_err), int'(!exp_ok));
            chk({nm, " busy end"}, int'(o_busy), 0);
            chk({nm, " last end"}, int'(o_last), 0);
            @(posedge clk) #1;
            @(negedge clk);
            chk({nm, " pulse width"}, int'(o_done | o_err), 0);
         end
         @(posedge clk) #1;
      end
      chk({nm, " finished"}, int'(fin), 1);
      i_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"diag",     1,  2, 2, 0, 3, {10'h000, 10'h000, 10'h021, 10'h042}, 1'b1};
      vecs[1] = '{"mixed",    2,  2, 1, 0, 4, {10'h000, 10'h020, 10'h021, 10'h041}, 1'b1};
      vecs[2] = '{"mixed_bp", 2,  2, 1, 1, 4, {10'h000, 10'h020, 10'h021, 10'h041}, 1'b1};
      vecs[3] = '{"broken",   3,  2, 2, 0, 2, {10'h000, 10'h000, 10'h021, 10'h042}, 1'b0};
      vecs[4] = '{"bad_tend", 1, 31, 0, 0, 0, {10'h000, 10'h000, 10'h000, 10'h000}, 1'b0};
      vecs[5] = '{"bad_rend", 1,  0, 31, 0, 0, {10'h000, 10'h000, 10'h000, 10'h000}, 1'b0};
      vecs[6] = '{"up_at_t0", 4,  0, 2, 0, 1, {10'h000, 10'h000, 10'h000, 10'h002}, 1'b0};
      vecs[7] = '{"origin",   0,  0, 0, 2, 1, {10'h000, 10'h000, 10'h000, 10'h000}, 1'b1};

      // Reset values
      @(negedge clk);
      chk("reset valid", int'(o_valid), 0);
      chk("reset index", int'(o_index), 0);
      chk("reset flags", int'({o_last, o_busy, o_done, o_err}), 0);
      do_reset();

      // Directed table
      for (int i = 0; i < 8; i++) begin
         do_reset();
         setup(vecs[i].setup);
         exp_q.delete();
         for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].beats[j]);
         exp_ok = vecs[i].ok;
         start(vecs[i].te, vecs[i].re);
         watch(vecs[i].nm, vecs[i].rmode);
      end

      // Writes during EMIT must be dropped
      do_reset();
      setup(1);
      start(2, 2);
      i_ready = 1'b0;
      i_wr_en = 1'b1; i_wr_tindex = 5'd2; i_wr_rindex = 5'd2; i_wr_path = 2'b00;
      @(posedge clk) #1;
      i_wr_tindex = 5'd1; i_wr_rindex = 5'd1;
      @(posedge clk) #1;
      i_wr_en = 1'b0;
      build(2, 2);
      watch("busy_write", 0);

      // Reset during the second beat clears outputs and the path
      do_reset();
      setup(1);
      start(2, 2);
      i_ready = 1'b1;
      @(posedge clk) #1;
      nrst = 1'b0;
      #1;
      chk("midrst valid", int'(o_valid), 0);
      chk("midrst index", int'(o_index), 0);
      chk("midrst flags", int'({o_last, o_busy, o_done, o_err}), 0);
      i_ready = 1'b0;
      @(posedge clk) #1;
      nrst = 1'b1;
      model_clear();
      @(posedge clk) #1;
      build(1, 1);
      start(1, 1);
      watch("after_rst", 0);

      // Randomized paths with noise writes and random backpressure
      for (int it = 0; it < 40; it++) begin
         int te;
         int re;
         int t;
         int r;
         int mv;
         do_reset();
         te = $urandom_range(0, 30);
         re = $urandom_range(0, 30);
         if (it % 10 == 9) te = 31;
         t = te;
         r = re;
         while (te < 31 && !(t == 0 && r == 0)) begin
            if (t > 0 && r > 0) mv = $urandom_range(1, 3);
            else if (t > 0) mv = 2;
            else mv = 1;
            wr(t, r, mv);
            if (mv == 3) begin t--; r--; end
            else if (mv == 2) t--;
            else r--;
         end
         for (int k = 0; k < 4; k++)
            wr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3));
         build(te, re);
         start(te, re);
         watch("random", 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
